// File: rtl/bram_search_engine.sv
// Block RAM with a built-in linear search engine. The host reads and writes through a cs/oe/we port.
// A start/busy/done handshake scans every word for a key and reports the first match or the match count.
module bram_search_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     we,
  input  logic                     oe,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    key,
  input  logic                     mode,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [ADDRESS_WIDTH-1:0] position,
  output logic [ADDRESS_WIDTH:0]   match_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_W = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST    = ADDRESS_WIDTH'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    key_q, key_d;
  logic                     mode_q, mode_d;
  logic                     cmp_vld_q, cmp_vld_d;
  logic [ADDRESS_WIDTH-1:0] cmp_idx_q, cmp_idx_d;
  logic [DATA_WIDTH-1:0]    rd_q, rd_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     found_q, found_d;
  logic [ADDRESS_WIDTH-1:0] pos_q, pos_d;
  logic [ADDRESS_WIDTH:0]   mcnt_q, mcnt_d;

  logic          host_in_range, mem_we, host_rd, hit;
  logic [IW-1:0] host_idx, rd_idx;
  logic [DATA_WIDTH-1:0] mem_rd;

  assign host_in_range = ({1'b0, address} < DEPTH_W);
  assign host_idx      = address[IW-1:0];
  // One shared read port: the scan counter owns it while scanning, the host otherwise.
  assign rd_idx        = (state_q == SCAN) ? cnt_q[IW-1:0] : host_idx;
  assign mem_rd        = mem[rd_idx];
  assign hit           = cmp_vld_q && (state_q == SCAN || state_q == DRAIN) && (rd_q == key_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    mode_d    = mode_q;
    cmp_vld_d = 1'b0;
    cmp_idx_d = cnt_q;
    rd_d      = rd_q;
    dout_d    = dout_q;
    found_d   = found_q;
    pos_d     = pos_q;
    mcnt_d    = mcnt_q;
    mem_we    = 1'b0;
    host_rd   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          mode_d  = mode;
          found_d = 1'b0;
          pos_d   = '0;
          mcnt_d  = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end else begin
          mem_we  = cs && we && host_in_range;
          host_rd = cs && oe && !we;
        end
      end
      SCAN: begin
        rd_d      = mem_rd;
        cmp_vld_d = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (host_rd) dout_d = host_in_range ? mem_rd : '0;

    // Compare stage trails issue by one cycle; a first-match hit overrides the scan's next state.
    if (hit) begin
      mcnt_d = mcnt_q + 1'b1;
      if (!found_q) begin
        found_d = 1'b1;
        pos_d   = cmp_idx_q;
      end
      if (!mode_q) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[host_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      rd_q      <= '0;
      dout_q    <= '0;
      found_q   <= 1'b0;
      pos_q     <= '0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      mode_q    <= mode_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      rd_q      <= rd_d;
      dout_q    <= dout_d;
      found_q   <= found_d;
      pos_q     <= pos_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dout        = dout_q;
  assign found       = found_q;
  assign position    = pos_q;
  assign match_count = mcnt_q;

endmodule

// File: tb/tb_bram_search_engine.sv
// Scoreboard bench for bram_search_engine at DEPTH=8: directed writes, reads and searches.
// The driver queues expected results; a negedge monitor checks them as done/dout appear.
module tb_bram_search_engine;
  localparam int DW = 8, AW = 8, DEPTH = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cs = 1'b0, we = 1'b0, oe = 1'b0, start = 1'b0, mode = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] din = '0, key = '0;
  logic [DW-1:0] dout;
  logic          busy, done, found;
  logic [AW-1:0] position;
  logic [AW:0]   match_count;

  bram_search_engine #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe), .address(address), .din(din),
    .dout(dout), .start(start), .key(key), .mode(mode), .busy(busy), .done(done),
    .found(found), .position(position), .match_count(match_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int f; int p; int c; int due; } srch_t;
  typedef struct { int d; int due; } rd_t;
  srch_t sq[$];
  rd_t   rq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        srch_t e;
        e = sq.pop_front();
        chk("found", int'(found), e.f);
        chk("position", int'(position), e.p);
        chk("match_count", int'(match_count), e.c);
        chk("done_cycle", cyc, e.due);
      end
    end
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      rd_t r;
      r = rq.pop_front();
      chk("dout", int'(dout), r.d);
      chk("read_cycle", cyc, r.due);
    end
  end

  task automatic drive(input logic s, input logic c, input logic w, input logic o,
                       input int a, input int d, input int k, input logic m);
    @(negedge clk);
    start = s; cs = c; we = w; oe = o;
    address = AW'(a); din = DW'(d); key = DW'(k); mode = m;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic host_write(input int a, input int d);
    drive(0, 1, 1, 0, a, d, 0, 0);
  endtask

  task automatic host_read(input int a, input int exp);
    rd_t r;
    drive(0, 1, 0, 1, a, 0, 0, 0);
    r.d = exp; r.due = cyc + 1;
    rq.push_back(r);
  endtask

  // Launch a search; lat is the done cycle relative to the cycle start is driven.
  task automatic search(input int k, input logic m, input int f, input int p, input int c,
                        input int lat, input logic push);
    srch_t e;
    drive(1, 0, 0, 0, 0, 0, k, m);
    e.f = f; e.p = p; e.c = c; e.due = cyc + lat;
    if (push) sq.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      idle();
      #1;
      if (sq.size() == 0 && rq.size() == 0) break;
    end
    if (sq.size() != 0 || rq.size() != 0) begin
      chk({name, "_timeout"}, sq.size() + rq.size(), 0);
      sq.delete();
      rq.delete();
    end
  endtask

  initial begin
    int mem_init [DEPTH];
    mem_init = '{165, 3, 2, 0, 7, 3, 9, 3};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_position", int'(position), 0);
    chk("rst_match_count", int'(match_count), 0);
    chk("rst_dout", int'(dout), 0);

    for (int i = 0; i < DEPTH; i++) host_write(i, mem_init[i]);
    host_write(8, 55);                 // out of range: must not alias onto address 0
    host_read(0, 165);
    host_read(1, 3);
    host_read(2, 2);
    host_read(8, 0);
    host_read(0, 165);
    wait_idle("reads");

    // First match, with a same-cycle host write that start must override.
    begin
      srch_t e;
      drive(1, 1, 1, 0, 2, 77, 3, 0);
      e.f = 1; e.p = 1; e.c = 1; e.due = cyc + 4;
      sq.push_back(e);
    end
    wait_idle("mode0_key3");
    host_read(2, 2);
    wait_idle("read_after_start_write");

    // Count all; a second start and a host write while busy must both be ignored.
    search(3, 1, 1, 1, 3, 10, 1);
    drive(1, 1, 1, 0, 0, 99, 42, 0);
    chk("busy_during_scan", int'(busy), 1);
    wait_idle("mode1_key3");
    repeat (14) idle();
    host_read(0, 165);
    wait_idle("read_after_busy_write");

    search(42, 0, 0, 0, 0, 10, 1);
    wait_idle("mode0_absent");
    search(42, 1, 0, 0, 0, 10, 1);
    wait_idle("mode1_absent");

    // Reset in the middle of a count-all scan: no done, results cleared.
    search(3, 1, 0, 0, 0, 0, 0);
    repeat (3) idle();
    @(negedge clk);
    chk("found_before_rst", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_found", int'(found), 0);
    chk("midrst_position", int'(position), 0);
    chk("midrst_match_count", int'(match_count), 0);
    repeat (14) idle();

    search(165, 0, 1, 0, 1, 3, 1);
    wait_idle("after_rst_key165");
    repeat (3) idle();

    chk("scoreboard_empty", sq.size() + rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
